// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side prefetch stage.
//  - RD_LAT_MIN / RD_LAT_MAX : legal range of upstream read latency
//  - cnt_w(depth)            : bits needed to count 0..depth
//  - inflt_w(lat)            : width of the in-flight counter; at least 1 bit
//                              so that a zero-latency configuration still has
//                              a legal port width
package fifo_pkg;

  localparam int RD_LAT_MIN = 0;
  localparam int RD_LAT_MAX = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int inflt_w(input int lat);
    return (lat > 0) ? cnt_w(lat) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_lat_pipe.sv
// Valid-bit shift register that mirrors the upstream FIFO read latency.
// Ports:
//  clk_i    in   clock, posedge
//  rst_ni   in   asynchronous active-low reset, clears every stage
//  issue_i  in   a FIFO read is issued this cycle
//  cap_o    out  the read data on the FIFO data bus is valid this cycle
//  inflt_o  out  number of reads issued but not yet captured (set bits in pipe)
// LAT=0 degenerates to a wire: data returns in the same cycle as the read.
module fifo_rd_lat_pipe
  import fifo_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_i,
  output logic                  cap_o,
  output logic [inflt_w(LAT)-1:0] inflt_o
);

  localparam int INF_W = inflt_w(LAT);

  if (LAT == 0) begin : g_pass
    assign cap_o   = issue_i;
    assign inflt_o = '0;
  end else begin : g_pipe
    logic [LAT-1:0] vld_q, vld_d;
    logic [INF_W-1:0] ones;

    always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = issue_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end

    // The last stage is still counted as in flight: it lands in the skid
    // buffer at the coming edge, so it has already consumed a slot.
    always_comb begin
      ones = '0;
      for (int i = 0; i < LAT; i++) begin
        ones = ones + INF_W'(vld_q[i]);
      end
    end

    assign cap_o   = vld_q[LAT-1];
    assign inflt_o = ones;
  end

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage for a pointer-based FIFO whose read data returns
// RD_LATENCY cycles after the pop. Reads are issued ahead of demand against
// a credit of free skid-buffer slots, so the output stream sustains one word
// per cycle regardless of the upstream latency.
// Ports:
//  clk_i         in   clock, posedge
//  rst_ni        in   asynchronous active-low reset
//  fifo_empty_i  in   upstream FIFO empty flag
//  fifo_rd_en_o  out  pop request to upstream FIFO
//  fifo_data_i   in   upstream read data, valid RD_LATENCY cycles after the pop
//  m_valid_o     out  output word valid
//  m_ready_i     in   downstream accepts the word
//  m_data_o      out  output word, driven from registered storage only
//  buf_count_o   out  words currently held in the skid buffer
module fifo_rd_prefetch
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        fifo_empty_i,
  output logic                        fifo_rd_en_o,
  input  logic [WIDTH-1:0]            fifo_data_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [WIDTH-1:0]            m_data_o,
  output logic [cnt_w(BUF_DEPTH)-1:0] buf_count_o
);

  localparam int CNT_W  = cnt_w(BUF_DEPTH);
  localparam int CRED_W = $clog2(BUF_DEPTH + 2);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int INF_W  = inflt_w(RD_LATENCY);

  if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_lat
    $error("fifo_rd_prefetch: RD_LATENCY %0d outside %0d..%0d",
           RD_LATENCY, RD_LAT_MIN, RD_LAT_MAX);
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("fifo_rd_prefetch: BUF_DEPTH %0d cannot cover RD_LATENCY %0d",
           BUF_DEPTH, RD_LATENCY);
  end

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  buf_q [BUF_DEPTH];
  logic              pop;
  logic              cap;
  logic              rd_en;
  logic [INF_W-1:0]  inflt;
  logic [CRED_W-1:0] used;

  assign pop = (count_q != '0) & m_ready_i;

  // Slots committed after this cycle: held words plus reads still on their
  // way, minus the word leaving now. Issuing only while this is below the
  // depth means every in-flight word is guaranteed a slot when it lands.
  // pop implies count_q >= 1, so the subtraction cannot wrap.
  assign used  = CRED_W'(count_q) + CRED_W'(inflt) - CRED_W'(pop);
  assign rd_en = ~fifo_empty_i & (used < CRED_W'(BUF_DEPTH));

  fifo_rd_lat_pipe #(
    .LAT (RD_LATENCY)
  ) u_lat_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .issue_i (rd_en),
    .cap_o   (cap),
    .inflt_o (inflt)
  );

  // Pointers wrap explicitly so the depth need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (cap) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (cap & ~pop) begin
      count_d = count_q + 1'b1;
    end else if (pop & ~cap) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Data storage carries no reset; only the count qualifies its contents.
  always_ff @(posedge clk_i) begin
    if (cap) begin
      buf_q[wr_ptr_q] <= fifo_data_i;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_valid_o    = (count_q != '0);
  assign m_data_o     = buf_q[rd_ptr_q];
  assign buf_count_o  = count_q;

  // A landing word must always find a free slot.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cap && (count_q == CNT_W'(BUF_DEPTH)) && !pop));

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Self-checking bench for fifo_rd_prefetch. Four lanes run the same stimulus
// against read latencies 0, 1, 2 and 4. Each lane owns a behavioural upstream
// FIFO with the matching read latency and a scoreboard queue that collects
// every word written into the FIFO; words are popped and compared as the DUT
// hands them out. Timing-specific expectations (first-word latency, buffer
// saturation level, throughput) are derived from the lane's latency.
module tb_fifo_rd_prefetch;

  localparam int SRC_N     = 16384;
  localparam int CMD_IDLE  = 0;
  localparam int CMD_SAT   = 1;
  localparam int CMD_RUN   = 2;
  localparam int CMD_SNAP  = 3;
  localparam int CMD_POPS  = 4;

  logic       clk;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] src [SRC_N];
  int         wcnt = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         cmd = 0;
  int         expVal = 0;
  event       cmdEv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // All comparisons funnel through here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int L  = (g == 3) ? 4 : g;
    localparam int D  = L + 1;
    localparam int CW = fifo_pkg::cnt_w(D);

    logic          empty;
    logic          rd_en;
    logic          valid;
    logic [7:0]    fdata;
    logic [7:0]    mdata;
    logic [CW-1:0] cnt;
    int            rcnt = 0;
    int            seen = 0;
    logic [7:0]    dly [5];
    logic [7:0]    sb [$];
    int            pops = 0;
    int            popBase = 0;
    int            curRun = 0;
    int            lastRun = 0;
    int            firstIssue = -1;
    int            firstValid = -1;
    logic          prevValid = 1'b0;
    logic          prevReady = 1'b0;
    logic [7:0]    prevData = '0;

    function automatic string tg(input string s);
      return $sformatf("lat%0d_%s", L, s);
    endfunction

    fifo_rd_prefetch #(
      .WIDTH      (8),
      .RD_LATENCY (L)
    ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .fifo_empty_i (empty),
      .fifo_rd_en_o (rd_en),
      .fifo_data_i  (fdata),
      .m_valid_o    (valid),
      .m_ready_i    (ready),
      .m_data_o     (mdata),
      .buf_count_o  (cnt)
    );

    // Upstream FIFO model: pops on rd_en and returns the word L cycles later.
    assign empty = (rcnt == wcnt);
    if (L == 0) begin : g_comb
      assign fdata = src[rcnt[13:0]];
    end else begin : g_sram
      assign fdata = dly[L-1];
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt <= wcnt;
        for (int i = 0; i < 5; i++) dly[i] <= 8'hxx;
      end else begin
        if (rd_en) rcnt <= rcnt + 1;
        dly[0] <= rd_en ? src[rcnt[13:0]] : 8'hxx;
        for (int i = 1; i < 5; i++) dly[i] <= dly[i-1];
      end
    end

    // Outputs must clear as soon as reset asserts, without a clock edge.
    always @(negedge rst_n) begin
      #1;
      if (!rst_n) begin
        checkOutput(tg("async_rst_valid"), valid, 0);
        checkOutput(tg("async_rst_rden"), rd_en, 0);
        checkOutput(tg("async_rst_cnt"), cnt, 0);
      end
    end

    // Per-cycle monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
      if (!rst_n) begin
        sb.delete();
        seen       = wcnt;
        prevValid  = 1'b0;
        prevReady  = 1'b0;
        firstIssue = -1;
        firstValid = -1;
        curRun     = 0;
        checkOutput(tg("rst_valid"), valid, 0);
        checkOutput(tg("rst_rden"), rd_en, 0);
        checkOutput(tg("rst_cnt"), cnt, 0);
      end else begin
        while (seen < wcnt) begin
          sb.push_back(src[seen]);
          seen++;
        end
        if (rd_en) begin
          checkOutput(tg("rd_nonempty"), rcnt < wcnt, 1);
          if (firstIssue < 0) firstIssue = cyc;
        end
        if (valid && firstValid < 0) begin
          firstValid = cyc;
          checkOutput(tg("valid_after_issue"), firstIssue >= 0, 1);
          if (firstIssue >= 0)
            checkOutput(tg("first_latency"), firstValid - firstIssue, L + 1);
        end
        if (prevValid && !prevReady) begin
          checkOutput(tg("hold_valid"), valid, 1);
          checkOutput(tg("hold_data"), mdata, prevData);
        end
        if (valid && ready) begin
          checkOutput(tg("sb_nonempty"), sb.size() != 0, 1);
          if (sb.size() != 0) checkOutput(tg("data"), mdata, sb.pop_front());
          pops++;
          curRun++;
        end else if (curRun > 0) begin
          lastRun = curRun;
          curRun  = 0;
        end
        checkOutput(tg("cnt_le_depth"), cnt <= D, 1);
        prevValid = valid;
        prevReady = ready;
        prevData  = mdata;
      end
    end

    // Point checks requested by the main sequence.
    always begin
      @(cmdEv);
      case (cmd)
        CMD_IDLE: begin
          checkOutput(tg("idle_sb_empty"), sb.size(), 0);
          checkOutput(tg("idle_valid"), valid, 0);
          checkOutput(tg("idle_rden"), rd_en, 0);
          checkOutput(tg("idle_cnt"), cnt, 0);
        end
        CMD_SAT: begin
          checkOutput(tg("sat_cnt"), cnt, D);
          checkOutput(tg("sat_rden"), rd_en, 0);
          checkOutput(tg("sat_valid"), valid, 1);
        end
        CMD_RUN:  checkOutput(tg("run_length"), lastRun, expVal);
        CMD_SNAP: popBase = pops;
        CMD_POPS: checkOutput(tg("pop_count"), pops - popBase, expVal);
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    if (wcnt < SRC_N - 1) begin
      src[wcnt] = w;
      wcnt++;
    end
  endtask

  task automatic issueCmd(input int c, input int e);
    @(negedge clk);
    #2;
    cmd    = c;
    expVal = e;
    ->cmdEv;
    #1;
  endtask

  initial begin
    $display("[TB] reset");
    repeat (3) tick();
    issueCmd(CMD_IDLE, 0);
    tick();
    rst_n = 1'b1;

    $display("[TB] single word latency");
    tick();
    ready = 1'b1;
    applyStimulus(8'hA5);
    repeat (8) tick();
    issueCmd(CMD_IDLE, 0);

    $display("[TB] streaming 16 words");
    issueCmd(CMD_SNAP, 0);
    tick();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i));
    repeat (25) tick();
    issueCmd(CMD_RUN, 16);
    issueCmd(CMD_POPS, 16);
    issueCmd(CMD_IDLE, 0);

    $display("[TB] backpressure");
    issueCmd(CMD_SNAP, 0);
    tick();
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i));
    repeat (3) tick();
    ready = 1'b0;
    repeat (10) tick();
    issueCmd(CMD_SAT, 0);
    tick();
    ready = 1'b1;
    repeat (30) tick();
    issueCmd(CMD_POPS, 16);
    issueCmd(CMD_IDLE, 0);

    $display("[TB] drain to empty and refill");
    issueCmd(CMD_SNAP, 0);
    tick();
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h80 + i));
    repeat (15) tick();
    issueCmd(CMD_POPS, 5);
    issueCmd(CMD_IDLE, 0);
    issueCmd(CMD_SNAP, 0);
    tick();
    applyStimulus(8'h5A);
    repeat (10) tick();
    issueCmd(CMD_POPS, 1);
    issueCmd(CMD_IDLE, 0);

    $display("[TB] reset mid-burst");
    tick();
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'hC0 + i));
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    issueCmd(CMD_IDLE, 0);
    tick();
    applyStimulus(8'hA5);
    repeat (8) tick();
    issueCmd(CMD_IDLE, 0);

    $display("[TB] random traffic");
    repeat (10000) begin
      tick();
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) applyStimulus(8'($urandom_range(0, 255)));
    end
    tick();
    ready = 1'b1;
    repeat (2000) tick();
    issueCmd(CMD_IDLE, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
